// File: rtl/irq_ctrl_8_v_pkg.sv
// Shared definitions for the interrupt controller and its priority-encoder path.
package irq_ctrl_8_v_pkg;

    localparam int NUM_LINES = 8;
    localparam int CODE_W    = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ASSERT = 1'b1
    } irq_state_e;

    function automatic logic [NUM_LINES-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
        logic [NUM_LINES-1:0] vec;
        vec = '0;
        vec[code] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/priority_enc_8_3_v.sv
// 8-to-3 priority encoder; the highest set index wins, any flags a nonzero input.
module priority_enc_8_3_v
    import irq_ctrl_8_v_pkg::*;
(
    input  logic [NUM_LINES-1:0] enc_in,
    output logic [CODE_W-1:0]    code,
    output logic                 any
);

    // Ascending scan: a later (higher) hit overwrites a lower one.
    always_comb begin
        code = '0;
        any  = 1'b0;
        for (int k = 0; k < NUM_LINES; k++) begin
            if (enc_in[k]) begin
                code = CODE_W'(k);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl_8_v.sv
// Eight-line interrupt controller: edge/level capture, pending/overrun tracking,
// masked priority dispatch and a valid/ack handshake toward the consumer.
module irq_ctrl_8_v
    import irq_ctrl_8_v_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_LINES-1:0] i_req,
    input  logic [NUM_LINES-1:0] i_mask,
    input  logic                 i_irq_ack,
    input  logic                 i_ovr_clr,
    output logic                 o_irq_valid,
    output logic [CODE_W-1:0]    o_irq_code,
    output logic [NUM_LINES-1:0] o_pending,
    output logic [NUM_LINES-1:0] o_overrun
);

    irq_state_e           state, state_d;
    logic [CODE_W-1:0]    code_q, code_d;
    logic [NUM_LINES-1:0] req_d, pending, overrun;
    logic [NUM_LINES-1:0] set_vec, clr_vec, ovr_set, eligible;
    logic [CODE_W-1:0]    enc_code;
    logic                 enc_any;

    assign set_vec  = EDGE_MODE ? (i_req & ~req_d) : i_req;
    assign clr_vec  = (state == ST_ASSERT && i_irq_ack) ? code_to_onehot(code_q) : '0;
    // Level mode re-asserts every cycle, so overrun would be meaningless there.
    assign ovr_set  = EDGE_MODE ? (set_vec & pending & ~clr_vec) : '0;
    assign eligible = pending & i_mask;

    priority_enc_8_3_v u_enc (
        .enc_in (eligible),
        .code   (enc_code),
        .any    (enc_any)
    );

    always_comb begin
        state_d = state;
        code_d  = code_q;
        case (state)
            ST_IDLE: begin
                if (enc_any) begin
                    state_d = ST_ASSERT;
                    code_d  = enc_code;
                end
            end
            ST_ASSERT: begin
                if (i_irq_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            code_q  <= '0;
            req_d   <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            state   <= state_d;
            code_q  <= code_d;
            req_d   <= i_req;
            pending <= (pending & ~clr_vec) | set_vec;
            overrun <= i_ovr_clr ? '0 : (overrun | ovr_set);
        end
    end

    assign o_irq_valid = (state == ST_ASSERT);
    assign o_irq_code  = code_q;
    assign o_pending   = pending;
    assign o_overrun   = overrun;

endmodule

// File: tb/tb_irq_ctrl_8_v.sv
// Directed bench for irq_ctrl_8_v: an edge-mode and a level-mode instance side by side.
module tb_irq_ctrl_8_v;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req, mask, lreq, lmask;
    logic       ack, ovr_clr, lack, lovr_clr;
    logic       vld, lvld;
    logic [2:0] code, lcode;
    logic [7:0] pend, ovr, lpend, lovr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irq_ctrl_8_v #(.EDGE_MODE(1'b1)) dut_e (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_mask(mask),
        .i_irq_ack(ack), .i_ovr_clr(ovr_clr),
        .o_irq_valid(vld), .o_irq_code(code), .o_pending(pend), .o_overrun(ovr)
    );

    irq_ctrl_8_v #(.EDGE_MODE(1'b0)) dut_l (
        .i_clk(clk), .i_rst(rst), .i_req(lreq), .i_mask(lmask),
        .i_irq_ack(lack), .i_ovr_clr(lovr_clr),
        .o_irq_valid(lvld), .o_irq_code(lcode), .o_pending(lpend), .o_overrun(lovr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; mask = 8'hFF; ack = 1'b0; ovr_clr = 1'b0;
        lreq = 8'h00; lmask = 8'hFF; lack = 1'b0; lovr_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_valid",   {7'b0, vld}, 8'h00);
        chk("rst_code",    {5'b0, code}, 8'h00);
        chk("rst_pending", pend, 8'h00);
        chk("rst_overrun", ovr, 8'h00);
        step(); step();
        chk("quiet_valid", {7'b0, vld}, 8'h00);

        // single edge on line 3
        req = 8'h08; step();
        chk("s_pend_n1",  pend, 8'h08);
        chk("s_valid_n1", {7'b0, vld}, 8'h00);
        req = 8'h00; step();
        chk("s_valid_n2", {7'b0, vld}, 8'h01);
        chk("s_code_n2",  {5'b0, code}, 8'h03);
        ack = 1'b1; step(); ack = 1'b0;
        chk("s_pend_ack",  pend, 8'h00);
        chk("s_valid_ack", {7'b0, vld}, 8'h00);

        // priority 7 over 1, back-to-back dispatch
        req = 8'h82; step(); req = 8'h00;
        chk("p_pend", pend, 8'h82);
        step();
        chk("p_valid7", {7'b0, vld}, 8'h01);
        chk("p_code7",  {5'b0, code}, 8'h07);
        ack = 1'b1; step(); ack = 1'b0;
        chk("p_gap_valid", {7'b0, vld}, 8'h00);
        chk("p_gap_pend",  pend, 8'h02);
        step();
        chk("p_valid1", {7'b0, vld}, 8'h01);
        chk("p_code1",  {5'b0, code}, 8'h01);
        ack = 1'b1; step(); ack = 1'b0;
        chk("p_idle_pend", pend, 8'h00);
        step();
        chk("p_idle_valid", {7'b0, vld}, 8'h00);

        // masking
        mask = 8'hEF; req = 8'h10; step(); req = 8'h00;
        chk("m_pend", pend, 8'h10);
        step(); step();
        chk("m_blocked", {7'b0, vld}, 8'h00);
        mask = 8'hFF; step(); step();
        chk("m_valid", {7'b0, vld}, 8'h01);
        chk("m_code",  {5'b0, code}, 8'h04);
        mask = 8'h00; step(); step();
        chk("m_hold_valid", {7'b0, vld}, 8'h01);
        chk("m_hold_code",  {5'b0, code}, 8'h04);
        ack = 1'b1; step(); ack = 1'b0;
        chk("m_ack_pend", pend, 8'h00);
        mask = 8'hFF;

        // overrun on line 2
        req = 8'h04; step(); req = 8'h00; step();
        chk("o_code", {5'b0, code}, 8'h02);
        req = 8'h04; step(); req = 8'h00;
        chk("o_set", ovr, 8'h04);
        ack = 1'b1; step(); ack = 1'b0;
        chk("o_sticky", ovr, 8'h04);
        chk("o_pend_ack", pend, 8'h00);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        chk("o_clr", ovr, 8'h00);

        // set/ack collision on line 2: set wins, no overrun
        req = 8'h04; step(); req = 8'h00; step();
        chk("c_valid", {7'b0, vld}, 8'h01);
        req = 8'h04; ack = 1'b1; step(); req = 8'h00; ack = 1'b0;
        chk("c_pend",  pend, 8'h04);
        chk("c_ovr",   ovr, 8'h00);
        chk("c_valid_drop", {7'b0, vld}, 8'h00);
        step();
        chk("c_redispatch", {4'b0, vld, code}, 8'h0A);
        ack = 1'b1; step(); ack = 1'b0;
        chk("c_final_pend", pend, 8'h00);

        // reset during ASSERT, then a stray ack
        req = 8'h01; step(); req = 8'h00; step();
        chk("r_valid_pre", {7'b0, vld}, 8'h01);
        rst = 1'b1; step(); rst = 1'b0;
        chk("r_valid", {7'b0, vld}, 8'h00);
        chk("r_code",  {5'b0, code}, 8'h00);
        chk("r_pend",  pend, 8'h00);
        ack = 1'b1; step(); ack = 1'b0;
        chk("r_ack_ignored", {7'b0, vld}, 8'h00);
        chk("r_ack_pend",    pend, 8'h00);

        // line held high through reset release counts as an edge;
        // level instance sees line 5 held high from the same point
        rst = 1'b1; req = 8'h20; lreq = 8'h20; step();
        rst = 1'b0; step();
        chk("h_pend",  pend, 8'h20);
        chk("l_pend",  lpend, 8'h20);
        step();
        chk("h_code", {4'b0, vld, code}, 8'h0D);
        chk("l_code", {4'b0, lvld, lcode}, 8'h0D);
        ack = 1'b1; lack = 1'b1; step(); ack = 1'b0; lack = 1'b0;
        chk("h_pend_ack", pend, 8'h00);
        chk("l_pend_ack", lpend, 8'h20);
        chk("l_valid_ack", {7'b0, lvld}, 8'h00);
        step();
        chk("h_no_redispatch", {7'b0, vld}, 8'h00);
        chk("l_recode", {4'b0, lvld, lcode}, 8'h0D);
        step(); step();
        chk("l_ovr", lovr, 8'h00);
        lack = 1'b1; step(); lack = 1'b0; step();
        chk("l_recode2", {4'b0, lvld, lcode}, 8'h0D);
        chk("l_ovr2", lovr, 8'h00);
        req = 8'h00; lreq = 8'h00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
